// File: rtl/serial_recv.sv
// Receive-side deserializer for a 2-bit-per-cycle DDR LVDS link.
// Hunts for word alignment on a training pattern, then emits one 32-bit word per 16 cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | compare both bit offsets against the training word each cycle
// ST_CONFIRM | offset chosen; check the training word at each word boundary
// ST_LOCKED  | alignment established; deliver the selected window each boundary
module serial_recv #(
    parameter logic [31:0] TRAIN_WORD = 32'hF0E1_4B2D,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        CLKS,
    input  logic        RSTS,
    input  logic [1:0]  DIN,
    input  logic        RESYNC,
    output logic [31:0] DOUT,
    output logic        DOUT_VALID,
    output logic        LOCKED,
    output logic        SEL
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic       LOCK_ONE = (LOCK_N == 4'd1);

    state_t      state_q, state_d;
    logic [32:0] hist_q, hist_d;
    logic [3:0]  pcnt_q, pcnt_d;
    logic [3:0]  mcnt_q, mcnt_d;
    logic        sel_q, sel_d;
    logic [31:0] dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        locked_q, locked_d;

    logic [31:0] win_a;
    logic [31:0] win_b;
    logic [31:0] win_sel;
    logic        match_a;
    logic        match_b;
    logic        match_sel;
    logic        boundary;
    logic [3:0]  mcnt_inc;

    // winB lags winA by one bit, covering words that start on a DIN[0] bit.
    assign win_a     = hist_q[31:0];
    assign win_b     = hist_q[32:1];
    assign win_sel   = sel_q ? win_b : win_a;
    assign match_a   = (win_a == TRAIN_WORD);
    assign match_b   = (win_b == TRAIN_WORD);
    assign match_sel = (win_sel == TRAIN_WORD);
    assign boundary  = (pcnt_q == 4'd15);
    assign mcnt_inc  = (mcnt_q == LOCK_N) ? mcnt_q : mcnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        hist_d       = {hist_q[30:0], DIN[1], DIN[0]};
        pcnt_d       = (state_q == ST_HUNT) ? pcnt_q : pcnt_q + 4'd1;
        mcnt_d       = mcnt_q;
        sel_d        = sel_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        locked_d     = locked_q;

        if (RESYNC) begin
            state_d  = ST_HUNT;
            pcnt_d   = 4'd0;
            mcnt_d   = 4'd0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    // winA takes priority when both offsets match.
                    if (match_a || match_b) begin
                        sel_d    = ~match_a;
                        pcnt_d   = 4'd0;
                        mcnt_d   = 4'd1;
                        state_d  = LOCK_ONE ? ST_LOCKED : ST_CONFIRM;
                        locked_d = LOCK_ONE;
                    end
                end
                ST_CONFIRM: begin
                    if (boundary) begin
                        if (match_sel) begin
                            mcnt_d = mcnt_inc;
                            if (mcnt_inc == LOCK_N) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            mcnt_d  = 4'd0;
                            pcnt_d  = 4'd0;
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        dout_d       = win_sel;
                        dout_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    pcnt_d   = 4'd0;
                    mcnt_d   = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLKS) begin
        if (RSTS) begin
            state_q      <= ST_HUNT;
            hist_q       <= '0;
            pcnt_q       <= '0;
            mcnt_q       <= '0;
            sel_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            pcnt_q       <= pcnt_d;
            mcnt_q       <= mcnt_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            locked_q     <= locked_d;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign LOCKED     = locked_q;
    assign SEL        = sel_q;

endmodule

// File: doc/serial_recv.md
Name: serial_recv

Overview:
- Receive-side deserializer for the 2-bit-per-CLKS DDR LVDS link.
- Consumes bit pairs already captured by the input DDR/IBUFDS primitives; the primitives sit outside this block.
- Finds 32-bit word alignment from a training word, then emits one 32-bit word every 16 CLKS cycles.
- Sits directly downstream of the transmit serializer, which sends MSB first, 2 bits per CLKS cycle, one word per 16 cycles.

Parameters:
- TRAIN_WORD, 32'hF0E1_4B2D: training pattern the transmitter sends until lock. No nonzero rotation of it may equal itself.
- LOCK_COUNT, 4: consecutive training matches, spaced 16 cycles apart, required to lock. Range 1..15.

Ports:
- CLKS  in  1  serial clock. Everything is on the rising edge.
- RSTS  in  1  reset, synchronous and active-high.
- DIN  in  2  bit pair captured this cycle. DIN[1] is the earlier bit (rising-edge sample), DIN[0] the later bit.
- RESYNC  in  1  synchronous pulse; forces re-hunt.
- DOUT  out  32  recovered word. Bit 31 is the first bit received.
- DOUT_VALID  out  1  one-cycle strobe; DOUT is new in that cycle.
- LOCKED  out  1  alignment established.
- SEL  out  1  alignment offset. 0 = word starts on a DIN[1] bit; 1 = word starts on a DIN[0] bit.

Behaviour:
- Reset (RSTS=1 at an edge): hist=0, state=HUNT, pcnt=0, mcnt=0, SEL=0, DOUT=0, DOUT_VALID=0, LOCKED=0.
- History register: each cycle hist[32:0] <= {hist[30:0], DIN[1], DIN[0]}. This update also runs during reset release and in every state.
- Word windows: winA = hist[31:0]; winB = hist[32:1]. The selected window is winA when SEL=0, winB when SEL=1.
- pcnt: 4-bit, increments every cycle outside HUNT, wraps 15->0. A word boundary is the cycle where pcnt==15.
- HUNT:
  - Every cycle, compare winA and winB with TRAIN_WORD.
  - winA match: SEL<=0, pcnt<=0, mcnt<=1, go to CONFIRM.
  - Else winB match: SEL<=1, pcnt<=0, mcnt<=1, go to CONFIRM.
  - If both match, winA wins.
  - If LOCK_COUNT==1, go directly to LOCKED instead of CONFIRM.
- CONFIRM:
  - At pcnt==15, compare the selected window with TRAIN_WORD.
  - Match: mcnt<=mcnt+1. If mcnt+1==LOCK_COUNT, go to LOCKED (LOCKED<=1).
  - Mismatch: mcnt<=0, go to HUNT.
  - Other pcnt values: no action.
- LOCKED:
  - At pcnt==15: DOUT<=selected window and DOUT_VALID<=1 on the next cycle.
  - DOUT_VALID is 0 on every other cycle. DOUT holds between strobes.
  - Training words received while locked are delivered as ordinary data; there is no lock-loss detection.
- Latency: the last bit pair of a word enters on DIN at cycle t. It sits in hist at t+1, where pcnt==15. DOUT and DOUT_VALID appear at t+2.
- RESYNC=1 (any state): next cycle state=HUNT, LOCKED=0, DOUT_VALID=0, mcnt=0, pcnt=0. DOUT keeps its last value. hist keeps shifting, so a training word already in hist can re-acquire on the following cycle.
- Reset or RESYNC in the same cycle as a boundary: reset/RESYNC wins and no strobe is issued.
- mcnt: 4 bits wide, saturating at LOCK_COUNT. It never exceeds 15.

Test Plan:
1. Reset, then stream TRAIN_WORD continuously with word-aligned DIN.
   - First match seen in hist at cycle t.
   - SEL=0, LOCKED=1 at t+49 (LOCK_COUNT=4), no DOUT_VALID before lock.
2. Same stream delayed by one bit (odd offset).
   - SEL=1, LOCKED at the same relative timing.
   - After lock, send 32'h1234_5678: DOUT=32'h1234_5678 with a single DOUT_VALID pulse.
3. After lock, send 32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF back-to-back.
   - Three DOUT_VALID pulses exactly 16 cycles apart, values in order.
4. Training with the 2nd word corrupted to 32'hF0E1_4B2C.
   - Return to HUNT at the boundary, LOCKED stays 0, mcnt cleared.
   - Relock after four clean words.
5. Locked and streaming: pulse RESYNC mid-word.
   - LOCKED=0 next cycle, no further DOUT_VALID, DOUT unchanged.
   - Resume training to relock.
   - Repeat the sequence with RSTS=1 instead: all outputs read 0 on the next cycle.
6. Random data containing a false TRAIN_WORD match at the wrong offset, followed by non-training data.
   - Enters CONFIRM, drops back to HUNT at the next boundary, LOCKED never asserts.
